// File: rtl/imem_loadable_if.sv
// Fetch and boot-loader signal bundle for imem_loadable.
// master = CPU/loader side, slave = memory side.
interface imem_loadable_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic [31:0]         addr;
  logic                en;
  logic [31:0]         data;
  logic                valid;
  logic                misalign;
  logic                load_start;
  logic                load_end;
  logic                load_byte_valid;
  logic [7:0]          load_byte;
  logic                load_busy;
  logic                load_done;
  logic [ADDR_WIDTH:0] load_count;
  logic                load_ovf;

  modport master (
    output addr, en, load_start, load_end, load_byte_valid, load_byte,
    input  data, valid, misalign, load_busy, load_done, load_count, load_ovf
  );

  modport slave (
    input  addr, en, load_start, load_end, load_byte_valid, load_byte,
    output data, valid, misalign, load_busy, load_done, load_count, load_ovf
  );
endinterface

// File: rtl/imem_loadable.sv
// Registered-read instruction memory with a byte-stream boot loader.
// Define IMEM_MISALIGN_CHECK_EN to flag and block fetches with addr[1:0] != 0.
module imem_loadable #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter logic [31:0] DEFAULT_WORD = 32'h8000_0000
) (
  input logic           clk,
  input logic           reset,
  imem_loadable_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, RECV, WRITE, FLUSH, DONE} state_t;

  state_t              state;
  logic [1:0]          byte_cnt;
  logic [31:0]         asm_word;
  logic [ADDR_WIDTH:0] wptr;
  logic                busy;
  logic                done;
  logic                ovf;
  logic                wr_en;

  logic [31:0]           mem [DEPTH] = '{default: DEFAULT_WORD};
  logic [31:0]           data_q;
  logic                  valid_q;
  logic                  mis_q;
  logic [ADDR_WIDTH-1:0] widx;
  logic                  in_range;
  logic                  misaligned;

  // Big-endian placement; bytes below the new one are zeroed so a flush pads with 0.
  function automatic logic [31:0] place(input logic [31:0] w, input logic [1:0] cnt,
                                        input logic [7:0] b);
    case (cnt)
      2'd0:    place = {b, 24'h0};
      2'd1:    place = {w[31:24], b, 16'h0};
      2'd2:    place = {w[31:16], b, 8'h0};
      default: place = {w[31:8], b};
    endcase
  endfunction

  // A restart in WRITE/FLUSH abandons the pending word along with the counters.
  assign wr_en = ((state == WRITE) || (state == FLUSH)) && !wptr[ADDR_WIDTH] && !bus.load_start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      byte_cnt <= '0;
      asm_word <= '0;
      wptr     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.load_start) begin
        state <= RECV;
        busy  <= 1'b1;
        wptr  <= '0;
        ovf   <= 1'b0;
        if (bus.load_byte_valid) begin
          asm_word <= {bus.load_byte, 24'h0};
          byte_cnt <= 2'd1;
        end else begin
          asm_word <= '0;
          byte_cnt <= '0;
        end
      end else begin
        unique case (state)
          IDLE: ;
          RECV: begin
            if (bus.load_byte_valid) begin
              asm_word <= place(asm_word, byte_cnt, bus.load_byte);
              byte_cnt <= byte_cnt + 2'd1;
              if (bus.load_end)            state <= FLUSH;
              else if (byte_cnt == 2'd3)   state <= WRITE;
            end else if (bus.load_end) begin
              if (byte_cnt != 2'd0) begin
                state <= FLUSH;
              end else begin
                state <= DONE;
                done  <= 1'b1;
              end
            end
          end
          WRITE: begin
            if (!wptr[ADDR_WIDTH]) wptr <= wptr + 1'b1;
            else                   ovf  <= 1'b1;
            // asm_word is being committed this cycle, so an incoming byte starts the next word
            if (bus.load_byte_valid) begin
              asm_word <= {bus.load_byte, 24'h0};
              byte_cnt <= 2'd1;
              state    <= bus.load_end ? FLUSH : RECV;
            end else begin
              byte_cnt <= '0;
              if (bus.load_end) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= RECV;
              end
            end
          end
          FLUSH: begin
            if (!wptr[ADDR_WIDTH]) wptr <= wptr + 1'b1;
            else                   ovf  <= 1'b1;
            state <= DONE;
            done  <= 1'b1;
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[ADDR_WIDTH-1:0]] <= asm_word;
  end

  assign widx     = bus.addr[ADDR_WIDTH+1:2];
  assign in_range = (bus.addr[31:ADDR_WIDTH+2] == '0);

`ifdef IMEM_MISALIGN_CHECK_EN
  assign misaligned = (bus.addr[1:0] != 2'b00);
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bus.addr[1:0];
  assign misaligned      = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= DEFAULT_WORD;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else if (busy) begin
      data_q  <= DEFAULT_WORD;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else if (bus.en) begin
      valid_q <= 1'b1;
      mis_q   <= misaligned;
      data_q  <= (in_range && !misaligned) ? mem[widx] : DEFAULT_WORD;
    end
  end

  assign bus.data       = data_q;
  assign bus.valid      = valid_q;
  assign bus.misalign   = mis_q;
  assign bus.load_busy  = busy;
  assign bus.load_done  = done;
  assign bus.load_count = wptr;
  assign bus.load_ovf   = ovf;
endmodule

// File: tb/tb_imem_loadable.sv
// Randomised directed bench for imem_loadable against a word-level image model.
module tb_imem_loadable;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 2 ** AW;
  localparam logic [31:0] DW    = 32'h8000_0000;

  typedef logic [7:0] byte_q_t [$];

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] ref_mem [DEPTH];
  int unsigned exp_count;
  logic        exp_ovf;

  imem_loadable_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loadable #(.ADDR_WIDTH(AW), .DEFAULT_WORD(DW)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_fetch(input logic [31:0] a);
`ifdef IMEM_MISALIGN_CHECK_EN
    if (a[1:0] != 2'b00) return DW;
`endif
    if ((a >> (AW + 2)) != 0) return DW;
    return ref_mem[(a >> 2) % DEPTH];
  endfunction

  function automatic logic exp_mis(input logic [31:0] a);
`ifdef IMEM_MISALIGN_CHECK_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0 & a[0];
`endif
  endfunction

  // Image model: bytes grouped big-endian into words, tail zero-padded, excess words dropped.
  task automatic model_load(input byte_q_t b, input bit finished);
    int unsigned nw;
    logic [31:0] word;
    nw = finished ? (b.size() + 3) / 4 : b.size() / 4;
    for (int unsigned w = 0; w < nw; w++) begin
      word = '0;
      for (int unsigned k = 0; k < 4; k++)
        if (4 * w + k < b.size()) word[31 - 8 * k -: 8] = b[4 * w + k];
      if (w < DEPTH) ref_mem[w] = word;
    end
    exp_count = (nw < DEPTH) ? nw : DEPTH;
    exp_ovf   = (nw > DEPTH);
  endtask

  task automatic fetch(input string tag, input logic [31:0] a);
    bus.en   = 1'b1;
    bus.addr = a;
    tick();
    chk({tag, ".data"}, bus.data, exp_fetch(a));
    chk({tag, ".valid"}, {31'b0, bus.valid}, 32'd1);
    chk({tag, ".mis"}, {31'b0, bus.misalign}, {31'b0, exp_mis(a)});
  endtask

  task automatic push_bytes(input byte_q_t b, input int unsigned first, input int unsigned last,
                            input bit gaps);
    for (int unsigned i = first; i < last; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        bus.load_byte_valid = 1'b0;
        tick();
      end
      bus.load_byte_valid = 1'b1;
      bus.load_byte       = b[i];
      tick();
    end
    bus.load_byte_valid = 1'b0;
  endtask

  task automatic send_image(input string tag, input byte_q_t b, input bit start_with_byte,
                            input bit end_with_byte, input bit gaps);
    int unsigned first, last, n;
    first = (start_with_byte && b.size() > 0) ? 1 : 0;
    last  = (end_with_byte && b.size() > first) ? b.size() - 1 : b.size();
    bus.load_start = 1'b1;
    if (first == 1) begin
      bus.load_byte_valid = 1'b1;
      bus.load_byte       = b[0];
    end
    tick();
    bus.load_start      = 1'b0;
    bus.load_byte_valid = 1'b0;
    push_bytes(b, first, last, gaps);
    tick();
    chk({tag, ".busy"}, {31'b0, bus.load_busy}, 32'd1);
    chk({tag, ".blocked_valid"}, {31'b0, bus.valid}, 32'd0);
    chk({tag, ".blocked_data"}, bus.data, DW);
    bus.load_end = 1'b1;
    if (last < b.size()) begin
      bus.load_byte_valid = 1'b1;
      bus.load_byte       = b[last];
    end
    tick();
    bus.load_end        = 1'b0;
    bus.load_byte_valid = 1'b0;
    model_load(b, 1'b1);
    n = 0;
    while (bus.load_done !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk({tag, ".done"}, {31'b0, bus.load_done}, 32'd1);
    chk({tag, ".count"}, 32'(bus.load_count), exp_count);
    chk({tag, ".ovf"}, {31'b0, bus.load_ovf}, {31'b0, exp_ovf});
    tick();
    chk({tag, ".done_pulse"}, {31'b0, bus.load_done}, 32'd0);
    chk({tag, ".idle"}, {31'b0, bus.load_busy}, 32'd0);
  endtask

  initial begin
    byte_q_t     img;
    logic [31:0] a;

    for (int unsigned i = 0; i < DEPTH; i++) ref_mem[i] = DW;
    bus.addr = '0; bus.en = 1'b0; bus.load_start = 1'b0; bus.load_end = 1'b0;
    bus.load_byte_valid = 1'b0; bus.load_byte = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst.data", bus.data, DW);
    chk("rst.valid", {31'b0, bus.valid}, 32'd0);
    chk("rst.mis", {31'b0, bus.misalign}, 32'd0);
    chk("rst.busy", {31'b0, bus.load_busy}, 32'd0);
    chk("rst.done", {31'b0, bus.load_done}, 32'd0);
    chk("rst.count", 32'(bus.load_count), 32'd0);
    chk("rst.ovf", {31'b0, bus.load_ovf}, 32'd0);
    rst_n = 1'b1;
    fetch("unloaded", 32'd0);

    img = '{8'h20, 8'h04, 8'h30, 8'h39, 8'hAF, 8'h24, 8'h00, 8'h0C};
    send_image("plan", img, 1'b0, 1'b0, 1'b0);
    chk("plan.w0", ref_mem[0], 32'h2004_3039);
    fetch("plan.a4", 32'd4);
    chk("plan.a4_lit", bus.data, 32'hAF24_000C);
    fetch("plan.a0", 32'd0);

    fetch("stall.pre", 32'd4);
    bus.en = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      bus.addr = 32'(8 * i);
      tick();
      chk("stall.data", bus.data, exp_fetch(32'd4));
      chk("stall.valid", {31'b0, bus.valid}, 32'd1);
    end
    fetch("stall.post", 32'd0);
    fetch("mis.a2", 32'd2);
    fetch("mis.a3", 32'd7);
    fetch("mis.aligned", 32'd4);

    img.delete();
    for (int unsigned i = 0; i < 4 * (DEPTH + 2) + 1; i++) img.push_back(8'($urandom));
    send_image("ovf", img, 1'b1, 1'b1, 1'b1);
    chk("ovf.count_lit", 32'(bus.load_count), DEPTH);
    fetch("ovf.oob", 32'(DEPTH * 4));
    fetch("ovf.last", 32'((DEPTH - 1) * 4));

    img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_image("part", img, 1'b0, 1'b0, 1'b0);
    chk("part.w1_lit", ref_mem[1], 32'h5566_0000);
    fetch("part.a4", 32'd4);

    // Abort after six bytes: only the first full word reaches memory before restart.
    img.delete();
    for (int unsigned i = 0; i < 6; i++) img.push_back(8'($urandom));
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    push_bytes(img, 0, 6, 1'b0);
    model_load(img, 1'b0);
    img.delete();
    for (int unsigned i = 0; i < 3; i++) img.push_back(8'($urandom));
    send_image("restart", img, 1'b1, 1'b0, 1'b0);
    fetch("restart.a0", 32'd0);
    fetch("restart.a4", 32'd4);

    for (int unsigned t = 0; t < 8; t++) begin
      img.delete();
      repeat ($urandom_range(0, 4 * DEPTH + 10)) img.push_back(8'($urandom));
      send_image("rand", img, 1'($urandom), 1'($urandom), 1'($urandom));
      for (int unsigned f = 0; f < 5; f++) begin
        a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEPTH * 4 + 7));
        fetch("rand.fetch", a);
      end
    end

    // Reset while the third byte of the second word is being presented.
    img.delete();
    for (int unsigned i = 0; i < 6; i++) img.push_back(8'($urandom));
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    push_bytes(img, 0, 6, 1'b0);
    model_load(img, 1'b0);
    bus.load_byte_valid = 1'b1;
    bus.load_byte       = 8'hEE;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.busy", {31'b0, bus.load_busy}, 32'd0);
    chk("midrst.count", 32'(bus.load_count), 32'd0);
    chk("midrst.valid", {31'b0, bus.valid}, 32'd0);
    bus.load_byte_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    fetch("midrst.a0", 32'd0);
    fetch("midrst.a4", 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_loadable.md
# imem_loadable

Parametrised, synchronous-read instruction memory for the pipelined CPU's IF stage, with a byte-stream boot loader.
- Replaces the fixed combinational program ROM: fetch data is registered (1-cycle latency), depth is configurable, and the fetch port honours pipeline stalls.
- Programs can be written at run time from a byte source (UART receiver) without resynthesis.
- Sits between the PC register and the IF/ID pipeline register.

## Interface
- ADDR_WIDTH, 8, word-index bits; DEPTH = 2**ADDR_WIDTH words (default 256)
- DEFAULT_WORD, 32'h80000000, word returned for out-of-range, blocked or unloaded fetches
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- addr  in  32  fetch byte address (PC); word index = addr[ADDR_WIDTH+1:2]
- en  in  1  fetch enable; 0 = stall, output held
- data  out  32  registered instruction word
- valid  out  1  data holds a real fetch result
- misalign  out  1  registered misaligned-fetch flag (see Configuration)
- load_start  in  1  one-cycle pulse: begin new image at word 0
- load_end  in  1  one-cycle pulse: finish image
- load_byte_valid  in  1  load_byte is presented this cycle
- load_byte  in  8  image byte, big-endian within word (first byte -> [31:24])
- load_busy  out  1  loader active; fetches blocked
- load_done  out  1  one-cycle pulse when load completes
- load_count  out  ADDR_WIDTH+1  words written by last or current load
- load_ovf  out  1  sticky: bytes dropped because image exceeded DEPTH; cleared by load_start

## Operation
- Storage: DEPTH x 32 array, initialised to DEFAULT_WORD at time 0; reset does not alter contents.
- Fetch, en=1 and not load_busy:
  - in range (addr[31:ADDR_WIDTH+2]==0): data <= mem[index], valid <= 1
  - otherwise: data <= DEFAULT_WORD, valid <= 1
- en=0: data, valid, misalign hold.
- load_busy=1: data <= DEFAULT_WORD, valid <= 0 every cycle regardless of en.
- Loader FSM states:
  - IDLE
    - load_start -> RECV; wptr=0, byte_cnt=0, load_count=0, load_ovf=0
    - load_end and load_byte_valid ignored
  - RECV
    - each load_byte_valid shifts byte into assembly register, byte_cnt++
    - at byte_cnt==3 with a valid byte -> WRITE
    - load_end -> FLUSH if byte_cnt!=0, else DONE
  - WRITE (1 cycle)
    - if wptr<DEPTH: mem[wptr] <= word, wptr++, load_count++
    - else: load_ovf <= 1, word dropped
    - byte_cnt=0; -> RECV
    - a load_byte_valid arriving here is accepted as byte 0 of the next word
  - FLUSH: write partial word, unfilled low bytes zero, same overflow rule -> DONE
  - DONE: load_done=1 for 1 cycle -> IDLE
- load_start in any non-IDLE state restarts: partial word discarded, counters cleared, -> RECV.
- load_start and load_byte_valid in the same cycle: byte taken as byte 0 of the new image.
- load_end and load_byte_valid in the same cycle: byte included before flush.
- load_busy = 1 in RECV, WRITE, FLUSH, DONE.

## Timing
- Reset values:
  - data=DEFAULT_WORD, valid=0, misalign=0
  - load_busy=0, load_done=0, load_count=0, load_ovf=0
  - FSM=IDLE, byte_cnt=0, wptr=0
- Fetch latency: 1 cycle (addr at edge N -> data after edge N).
- Write latency: word visible to a fetch issued the cycle after WRITE.
- First fetch after load_done: valid rises on the next enabled edge.
- Reset asserted mid-load: FSM to IDLE immediately; already-written words retained; partial word lost.
- Throughput: one byte per cycle sustained, including during WRITE.

## Configuration
- IMEM_MISALIGN_CHECK_EN:
  - defined: a fetch with addr[1:0]!=0 returns DEFAULT_WORD with valid=1 and misalign=1 (registered, held under stall); aligned fetches clear misalign.
  - undefined: addr[1:0] ignored, misalign tied 0.

## Test plan
- Reset with no load, en=1, addr=0 -> data=32'h80000000, valid=1 one cycle later.
- load_start + 8 bytes 20 04 30 39 AF 24 00 0C + load_end -> mem[0]=32'h20043039, mem[1]=32'hAF24000C, load_count=2, load_done one pulse; fetch addr=4 -> 32'hAF24000C.
- en held 0 for 3 cycles while addr changes -> data unchanged; en=1 -> new word next cycle.
- ADDR_WIDTH=2, load 5 words -> load_count=4, load_ovf=1; addr=16 -> DEFAULT_WORD.
- 6 bytes then load_end -> mem[1]={b4,b5,16'h0000}; reset during a 3rd byte -> FSM IDLE, mem[0] intact.
- With IMEM_MISALIGN_CHECK_EN, addr=2 -> data=32'h80000000, misalign=1; without it -> mem[0], misalign=0.
